soc_dma_burst_splitter: RTL and testbench

SOC_DMA_BURST_SPLITTER -- requirements
Module: soc_dma_burst_splitter

---
 rtl/soc_dma_burst_splitter.sv | 118 +++++++++++
 tb/tb_soc_dma_burst_splitter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_dma_burst_splitter.sv
// Splits a DMA transfer request into AXI bursts that never cross a 4 KiB page
// and never exceed MAX_BURST_LEN beats. Burst commands come straight from registered state.
`timescale 1ns/1ps
module soc_dma_burst_splitter #(
    parameter int AXI_AW        = 64,
    parameter int AXI_DW        = 64,
    parameter int MAX_BURST_LEN = 16,
    parameter int LEN_W         = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AXI_AW-1:0] req_addr_i,
    input  logic [LEN_W-1:0]  req_beats_i,
    output logic              burst_valid_o,
    input  logic              burst_ready_i,
    output logic [AXI_AW-1:0] burst_addr_o,
    output logic [7:0]        burst_len_o,
    output logic              burst_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int BPB = AXI_DW / 8;
    localparam int OFF = $clog2(BPB);
    localparam int CW  = (LEN_W > 13) ? LEN_W : 13;
    localparam logic [AXI_AW-1:0] ALIGN_MASK = ~((AXI_AW'(1) << OFF) - AXI_AW'(1));
    localparam logic [CW-1:0]     MAX_N      = CW'(MAX_BURST_LEN);

    typedef enum logic {IDLE, SPLIT} state_e;

    state_e              state_q, state_d;
    logic [AXI_AW-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic                done_q, done_d;

    logic [12:0]         pageBytes;
    logic [CW-1:0]       pageBeats;
    logic [CW-1:0]       chunkLimit;
    logic [CW-1:0]       chunk;
    logic                isLast;

    // Chunk size is the tightest of: beats left, burst cap, beats left in the 4 KiB page.
    assign pageBytes  = 13'h1000 - {1'b0, addr_q[11:0]};
    assign pageBeats  = CW'(pageBytes >> OFF);
    assign chunkLimit = (pageBeats < MAX_N) ? pageBeats : MAX_N;
    assign chunk      = (CW'(remain_q) < chunkLimit) ? CW'(remain_q) : chunkLimit;
    assign isLast     = (chunk == CW'(remain_q));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_beats_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = req_addr_i & ALIGN_MASK;
                        remain_d = req_beats_i;
                        state_d  = SPLIT;
                    end
                end
            end
            SPLIT: begin
                if (burst_ready_i) begin
                    addr_d   = addr_q + (AXI_AW'(chunk) << OFF);
                    remain_d = remain_q - LEN_W'(chunk);
                    if (isLast) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst fields are forced to zero outside SPLIT so idle and reset look identical.
    always_comb begin
        req_ready_o   = 1'b0;
        busy_o        = 1'b0;
        burst_valid_o = 1'b0;
        burst_addr_o  = '0;
        burst_len_o   = '0;
        burst_last_o  = 1'b0;
        done_o        = done_q;
        case (state_q)
            IDLE: req_ready_o = 1'b1;
            SPLIT: begin
                busy_o        = 1'b1;
                burst_valid_o = 1'b1;
                burst_addr_o  = addr_q;
                burst_len_o   = 8'(chunk - CW'(1));
                burst_last_o  = isLast;
            end
            default: req_ready_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_soc_dma_burst_splitter.sv
// Bench for soc_dma_burst_splitter: a transaction-level burst model compared every cycle,
// plus hand-computed burst sequences for the documented scenarios.
`timescale 1ns/1ps
module tb_soc_dma_burst_splitter;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int MBL = 16;
    localparam int LW  = 24;
    localparam int BPB = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reqValid = 1'b0;
    logic [AW-1:0] reqAddr = '0;
    logic [LW-1:0] reqBeats = '0;
    logic          burstReady = 1'b1;
    logic          randReady = 1'b0;

    logic          reqReady;
    logic          burstValid;
    logic [AW-1:0] burstAddr;
    logic [7:0]    burstLen;
    logic          burstLast;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic        last;
    } burst_t;

    burst_t expQ[$];
    logic   expDone = 1'b0;
    logic   nextDone;

    soc_dma_burst_splitter #(
        .AXI_AW(AW), .AXI_DW(DW), .MAX_BURST_LEN(MBL), .LEN_W(LW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(reqValid),
        .req_ready_o(reqReady),
        .req_addr_i(reqAddr),
        .req_beats_i(reqBeats),
        .burst_valid_o(burstValid),
        .burst_ready_i(burstReady),
        .burst_addr_o(burstAddr),
        .burst_len_o(burstLen),
        .burst_last_o(burstLast),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBurst(input string name, input logic v, input logic [63:0] a,
                              input logic [7:0] l, input logic last);
        checkOutput({name, ".valid"}, 64'(burstValid), 64'(v));
        checkOutput({name, ".addr"},  burstAddr, a);
        checkOutput({name, ".len"},   64'(burstLen), 64'(l));
        checkOutput({name, ".last"},  64'(burstLast), 64'(last));
    endtask

    // Expected burst list for one transfer, straight from the splitting rule.
    function automatic void buildBursts(input logic [63:0] a0, input logic [LW-1:0] beats);
        logic [63:0] a;
        int r, page, n;
        a = a0 & ~64'(BPB - 1);
        r = int'(beats);
        while (r > 0) begin
            page = (4096 - int'(a[11:0])) / BPB;
            n = r;
            if (n > MBL)  n = MBL;
            if (n > page) n = page;
            expQ.push_back('{addr: a, len: 8'(n - 1), last: (n == r)});
            a = a + 64'(n * BPB);
            r = r - n;
        end
    endfunction

    // Model: empty queue means idle; each accepted burst pops the head.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expQ.delete();
            expDone = 1'b0;
        end else begin
            nextDone = 1'b0;
            if (expQ.size() == 0) begin
                if (reqValid) begin
                    if (reqBeats == '0) nextDone = 1'b1;
                    else buildBursts(reqAddr, reqBeats);
                end
            end else if (burstReady) begin
                if (expQ[0].last) nextDone = 1'b1;
                void'(expQ.pop_front());
            end
            expDone = nextDone;
        end
    end

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            checkOutput("m.req_ready", 64'(reqReady), 64'(0));
            checkOutput("m.busy", 64'(busy), 64'(1));
            checkBurst("m.burst", 1'b1, expQ[0].addr, expQ[0].len, expQ[0].last);
        end else begin
            checkOutput("m.req_ready", 64'(reqReady), 64'(1));
            checkOutput("m.busy", 64'(busy), 64'(0));
            checkBurst("m.burst", 1'b0, 64'h0, 8'h0, 1'b0);
        end
        checkOutput("m.done", 64'(done), 64'(expDone));
    end

    always @(posedge clk) begin
        if (randReady) begin
            #1 burstReady = 1'($urandom_range(0, 1));
        end
    end

    task automatic applyStimulus(input logic [63:0] a, input logic [LW-1:0] b);
        int i;
        i = 0;
        @(posedge clk); #1;
        while (!reqReady && i < 1000) begin
            @(posedge clk); #1;
            i++;
        end
        if (!reqReady) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_wait: req_ready still 0 after %0d cycles", i);
        end
        reqValid = 1'b1;
        reqAddr  = a;
        reqBeats = b;
        @(posedge clk); #1;
        reqValid = 1'b0;
    endtask

    task automatic checkDone(input string name);
        @(negedge clk);
        checkOutput({name, ".done"}, 64'(done), 64'(1));
        checkOutput({name, ".req_ready"}, 64'(reqReady), 64'(1));
        checkOutput({name, ".valid"}, 64'(burstValid), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] vecAddr [4];
        logic [LW-1:0] vecBeats [4];
        int w;
        vecAddr[0] = 64'h0000_0000_0000_0FF8; vecBeats[0] = 24'd3;
        vecAddr[1] = 64'h0000_0000_0000_07F0; vecBeats[1] = 24'd300;
        vecAddr[2] = 64'h0000_0001_0000_0FF0; vecBeats[2] = 24'd5;
        vecAddr[3] = 64'hFFFF_FFFF_FFFF_FFF8; vecBeats[3] = 24'd3;

        repeat (3) @(negedge clk);
        checkOutput("reset.req_ready", 64'(reqReady), 64'(1));
        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.done", 64'(done), 64'(0));
        checkBurst("reset", 1'b0, 64'h0, 8'h0, 1'b0);
        rst = 1'b0;

        // 40 beats at 0x1000: 16 + 16 + 8 back to back
        applyStimulus(64'h1000, 24'd40);
        @(negedge clk); checkBurst("t1.b0", 1'b1, 64'h1000, 8'd15, 1'b0);
        @(negedge clk); checkBurst("t1.b1", 1'b1, 64'h1080, 8'd15, 1'b0);
        @(negedge clk); checkBurst("t1.b2", 1'b1, 64'h1100, 8'd7, 1'b1);
        checkDone("t1");

        // 4 KiB page edge after 8 beats
        applyStimulus(64'h1FC0, 24'd20);
        @(negedge clk); checkBurst("t2.b0", 1'b1, 64'h1FC0, 8'd7, 1'b0);
        @(negedge clk); checkBurst("t2.b1", 1'b1, 64'h2000, 8'd11, 1'b1);
        checkDone("t2");

        // zero-length request completes without a burst
        applyStimulus(64'h4000, 24'd0);
        checkDone("t3");
        @(negedge clk);
        checkOutput("t3.done_clear", 64'(done), 64'(0));

        // unaligned single beat
        applyStimulus(64'h1003, 24'd1);
        @(negedge clk); checkBurst("t4.b0", 1'b1, 64'h1000, 8'd0, 1'b1);
        checkDone("t4");

        // stalled first burst holds its fields
        burstReady = 1'b0;
        applyStimulus(64'h0, 24'd40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); checkBurst("t5.stall", 1'b1, 64'h0, 8'd15, 1'b0);
        end
        burstReady = 1'b1;
        @(negedge clk); checkBurst("t5.b1", 1'b1, 64'h80, 8'd15, 1'b0);
        @(negedge clk); checkBurst("t5.b2", 1'b1, 64'h100, 8'd7, 1'b1);
        checkDone("t5");

        // reset after the first burst handshake
        applyStimulus(64'h1000, 24'd40);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkBurst("t6.rst", 1'b0, 64'h0, 8'h0, 1'b0);
        checkOutput("t6.rst.req_ready", 64'(reqReady), 64'(1));
        checkOutput("t6.rst.busy", 64'(busy), 64'(0));
        checkOutput("t6.rst.done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t6.post.valid", 64'(burstValid), 64'(0));
            checkOutput("t6.post.req_ready", 64'(reqReady), 64'(1));
        end

        // boundary and wrap vectors with a jittery ready, checked by the model
        randReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(vecAddr[k], vecBeats[k]);
        end
        w = 0;
        @(posedge clk); #1;
        while (!reqReady && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        if (!reqReady) begin
            total++;
            bad++;
            $display("[TB] FAIL final_idle: req_ready still 0 after %0d cycles", w);
        end
        randReady = 1'b0;
        burstReady = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
